// File: rtl/key_debouncer_if.sv
// Key bundle between raw push-buttons and the debouncer: raw active-low keys in,
// debounced level/pulses/count out.
interface key_debouncer_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                key_any;
  logic [7:0]          key_count;

  modport master (
    output key_n,
    input  key_level, key_press, key_release, key_any, key_count
  );

  modport slave (
    input  key_n,
    output key_level, key_press, key_release, key_any, key_count
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-key debouncer: 2-flop sync, 4-state accept FSM with stability counter,
// registered press/release pulses and a modulo-256 count of accepted presses.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_KEYS        = 4
) (
  input logic           CLOCK_50,
  input logic           reset_n,
  key_debouncer_if.slave keys
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 1 of the encoding is the debounced level, so key_level comes straight off a flop.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  state_t              state     [NUM_KEYS];
  state_t              state_nxt [NUM_KEYS];
  logic [CW-1:0]       cnt       [NUM_KEYS];
  logic [CW-1:0]       cnt_nxt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] press_nxt;
  logic [NUM_KEYS-1:0] release_nxt;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] level;
  logic [7:0]          press_pop;
  logic [7:0]          count_q;

  // Synchronizers idle at 1 (released) so reset never looks like a press.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync_meta <= '1;
      sync      <= '1;
    end else begin
      sync_meta <= keys.key_n;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
      count_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      press_q   <= press_nxt;
      release_q <= release_nxt;
      count_q   <= count_q + press_pop;
    end
  end

  always_comb begin
    press_nxt   = '0;
    release_nxt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (!sync[i]) begin
            state_nxt[i] = PRESS_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync[i]) begin
            state_nxt[i] = IDLE;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = PRESSED;
            press_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CW'(1);
          end
        end
        PRESSED: begin
          if (sync[i]) begin
            state_nxt[i] = RELEASE_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sync[i]) begin
            state_nxt[i] = PRESSED;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i]   = IDLE;
            release_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CW'(1);
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Count is added at the same edge that registers the pulse, so both appear together.
  always_comb begin
    press_pop = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_pop = press_pop + 8'(press_nxt[i]);
      level[i]  = state[i][1];
    end
  end

  assign keys.key_level   = level;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;
  assign keys.key_any     = |level;
  assign keys.key_count   = count_q;

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000 (5 ms at 50 MHz), legal range >= 2: the number of consecutive stable synchronized samples required to accept a key change.
REQ-002 SHALL have parameter NUM_KEYS, default 4: the number of independent keys.
REQ-003 SHALL have port CLOCK_50, input, width 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, width 1: reset, synchronous, active-low.
REQ-005 SHALL have port key_n, input, width NUM_KEYS: raw push-buttons, asynchronous, active-low (0 = pressed).
REQ-006 SHALL have port key_level, output, width NUM_KEYS: debounced state, active-high (1 = pressed).
REQ-007 SHALL have port key_press, output, width NUM_KEYS: one-cycle pulse on each accepted press.
REQ-008 SHALL have port key_release, output, width NUM_KEYS: one-cycle pulse on each accepted release.
REQ-009 SHALL have port key_any, output, width 1: OR of key_level.
REQ-010 SHALL have port key_count, output, width 8: running total of accepted presses across all keys.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer; only the second flop output (sync) SHALL feed downstream logic.
REQ-012 Each key SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus its own counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 IDLE SHALL transition on sync==0 to PRESS_WAIT with the counter cleared to 0; otherwise it stays in IDLE.
REQ-014 PRESS_WAIT SHALL behave as follows:
- sync==1: return to IDLE (bounce rejected), with no output pulse.
- else, counter==DEBOUNCE_CYCLES-1: go to PRESSED and pulse key_press.
- else: increment the counter.
REQ-015 PRESSED SHALL transition on sync==1 to RELEASE_WAIT with the counter cleared to 0; otherwise it stays in PRESSED.
REQ-016 RELEASE_WAIT SHALL behave as follows:
- sync==0: return to PRESSED, with no pulse.
- else, counter==DEBOUNCE_CYCLES-1: go to IDLE and pulse key_release.
- else: increment the counter.
REQ-017 key_level SHALL be 1 exactly when the FSM is in PRESSED or RELEASE_WAIT.
REQ-018 key_press and key_release SHALL be registered, high for exactly one cycle per accepted transition, and never high in consecutive cycles for the same key.
REQ-019 Latency: for key_n held low from the first rising edge at which it is sampled low (edge 0), key_press SHALL be high during the cycle following edge DEBOUNCE_CYCLES+2, and key_level SHALL rise in the same cycle.
REQ-020 Release latency SHALL be symmetric to press latency: key_release is pulsed and key_level falls DEBOUNCE_CYCLES+2 edges after key_n is first sampled high.
REQ-021 Any sync change shorter than DEBOUNCE_CYCLES+1 cycles SHALL produce no pulse and no key_level change.
REQ-022 key_count SHALL add the population count of key_press each cycle, modulo 256: simultaneous presses add 1..NUM_KEYS in one cycle, and 255+1 wraps to 0.
REQ-023 key_any SHALL be a combinational OR of the registered key_level.
REQ-024 Keys SHALL be fully independent: activity on one key never alters another key's FSM or counter.

Reset
REQ-025 While reset_n==0 at a rising edge, the block SHALL do all of the following:
- set the synchronizer flops to 1;
- set every FSM to IDLE;
- clear every counter to 0;
- drive key_level, key_press, key_release, key_any and key_count to 0.
REQ-026 Reset asserted mid-PRESS_WAIT or mid-RELEASE_WAIT SHALL discard the pending transition and emit no pulse, both during reset and after it.
REQ-027 A key still held when reset_n returns high SHALL be debounced afresh, with key_press following REQ-019 timing counted from the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Hold key_n[0]=0 from edge 0 -> key_press[0]=1 only in the cycle after edge 6; key_level[0]=1 from then on; key_any=1; key_count=1.
REQ-029 Pulse key_n[1]=0 for 3 cycles, then return it to 1 -> key_press[1], key_level[1] and key_count all stay 0.
REQ-030 With key 2 pressed, drive key_n[2] with a 2-cycle high glitch, then hold it high -> no release on the glitch; key_release[2] pulses once, 6 edges after the final rise is first sampled; key_level[2] falls in the same cycle.
REQ-031 Drop key_n[0], key_n[2] and key_n[3] in the same cycle -> key_press=4'b1101 for one cycle; key_count increments by 3.
REQ-032 Preload key_count to 255 via 255 presses, then press once more -> key_count=0.
REQ-033 Hold key_n[3]=0 and pulse reset_n=0 for 2 cycles at counter=2 -> no pulse; all outputs 0 during reset; key_press[3] is pulsed 6 edges after reset_n is first sampled high.
